// File: rtl/mem_stage.sv
// Pipeline memory stage: resolves branches, runs loads/stores over a req/ack
// data-memory port with timeout, and retires one result per bundle to writeback.
module mem_stage #(
  parameter int DATA_W  = 32,
  parameter int REG_W   = 5,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [DATA_W-1:0] ex_pc_n,
  input  logic              ex_zero,
  input  logic [DATA_W-1:0] ex_alu_out,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic [REG_W-1:0]  ex_r_d,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic              ex_branch,
  input  logic              ex_reg_write,
  output logic              dm_req,
  output logic              dm_we,
  output logic [DATA_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic              dm_ack,
  input  logic [DATA_W-1:0] dm_rdata,
  output logic              br_taken,
  output logic [DATA_W-1:0] br_target,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [DATA_W-1:0] wb_data,
  output logic [REG_W-1:0]  wb_r_d,
  output logic              wb_reg_write,
  output logic              mem_err
);

  typedef enum logic [1:0] {IDLE, MEM_WAIT, WB_HOLD} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t              r_state, r_next, w_acc_state;
  logic [7:0]          r_cnt;
  logic                r_we, r_br_taken, r_wb_we, r_err;
  logic [DATA_W-1:0]   r_addr, r_wdata, r_br_target, r_wb_data;
  logic [REG_W-1:0]    r_wb_rd;
  logic                w_accept, w_mem_op, w_misalign, w_bad_addr, w_timeout;

  assign ex_ready   = (r_state == IDLE) || (r_state == WB_HOLD && wb_ready);
  assign w_accept   = ex_valid && ex_ready;
  assign w_mem_op   = ex_mem_read || ex_mem_write;
  assign w_misalign = ex_alu_out[1:0] != 2'b00;
  assign w_bad_addr = w_mem_op && w_misalign;
  // An ack on the final allowed cycle still completes the access.
  assign w_timeout  = (r_state == MEM_WAIT) && !dm_ack && (r_cnt == TO_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= r_next;
  end

  always_comb begin
    w_acc_state = (w_mem_op && !w_misalign) ? MEM_WAIT : WB_HOLD;
    r_next      = r_state;
    case (r_state)
      IDLE:     if (w_accept) r_next = w_acc_state;
      MEM_WAIT: if (dm_ack || w_timeout) r_next = WB_HOLD;
      WB_HOLD: begin
        if (w_accept)      r_next = w_acc_state;
        else if (wb_ready) r_next = IDLE;
      end
      default:  r_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt       <= '0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_br_taken  <= 1'b0;
      r_br_target <= '0;
      r_wb_data   <= '0;
      r_wb_rd     <= '0;
      r_wb_we     <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_br_taken <= w_accept && ex_branch && ex_zero;
      if (w_accept && ex_branch && ex_zero) r_br_target <= ex_pc_n;
      r_cnt <= (r_state == MEM_WAIT && r_next == MEM_WAIT) ? r_cnt + 8'd1 : 8'd0;
      if (w_accept) begin
        r_wb_rd   <= ex_r_d;
        r_wb_we   <= ex_reg_write && (ex_r_d != '0) && !w_bad_addr;
        // Stores keep alu_out as their retired value; loads overwrite it on ack.
        r_wb_data <= w_bad_addr ? '0 : ex_alu_out;
        if (w_bad_addr) r_err <= 1'b1;
        if (w_mem_op && !w_misalign) begin
          r_addr  <= ex_alu_out;
          r_we    <= ex_mem_write;
          r_wdata <= ex_store_data;
        end
      end else if (r_state == MEM_WAIT) begin
        if (dm_ack) begin
          if (!r_we) r_wb_data <= dm_rdata;
        end else if (w_timeout) begin
          r_wb_data <= '0;
          r_wb_we   <= 1'b0;
          r_err     <= 1'b1;
        end
      end
    end
  end

  assign dm_req       = (r_state == MEM_WAIT);
  assign dm_we        = r_we;
  assign dm_addr      = r_addr;
  assign dm_wdata     = r_wdata;
  assign br_taken     = r_br_taken;
  assign br_target    = r_br_target;
  assign wb_valid     = (r_state == WB_HOLD);
  assign wb_data      = r_wb_data;
  assign wb_r_d       = r_wb_rd;
  assign wb_reg_write = r_wb_we;
  assign mem_err      = r_err;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU, load, store, branch, error and reset cases.
module tb_mem_stage;
  logic        clk = 1'b0, rst = 1'b1;
  logic        ex_valid = 0, ex_zero = 0, ex_mem_read = 0, ex_mem_write = 0;
  logic        ex_branch = 0, ex_reg_write = 0, dm_ack = 0, wb_ready = 1;
  logic [31:0] ex_pc_n = 0, ex_alu_out = 0, ex_store_data = 0, dm_rdata = 0;
  logic [4:0]  ex_r_d = 0;
  logic        ex_ready, dm_req, dm_we, br_taken, wb_valid, wb_reg_write, mem_err;
  logic [31:0] dm_addr, dm_wdata, br_target, wb_data;
  logic [4:0]  wb_r_d;
  int          n_cmp = 0, n_bad = 0;

  mem_stage #(.DATA_W(32), .REG_W(5), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_pc_n(ex_pc_n), .ex_zero(ex_zero), .ex_alu_out(ex_alu_out),
    .ex_store_data(ex_store_data), .ex_r_d(ex_r_d), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_branch(ex_branch), .ex_reg_write(ex_reg_write),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata), .br_taken(br_taken), .br_target(br_target),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_r_d(wb_r_d),
    .wb_reg_write(wb_reg_write), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bundle(input logic [31:0] pc_n, alu, sd, input logic [4:0] rd,
                        input logic zero, mr, mw, br, rw);
    ex_pc_n = pc_n; ex_alu_out = alu; ex_store_data = sd; ex_r_d = rd;
    ex_zero = zero; ex_mem_read = mr; ex_mem_write = mw; ex_branch = br;
    ex_reg_write = rw; ex_valid = 1'b1;
  endtask

  // Acceptance edge, then drop valid just after it.
  task automatic accept_one();
    @(posedge clk); #1 ex_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  initial begin
    int n;
    // Reset state
    @(negedge clk);
    chk("rst_dm_req", dm_req, 0);    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_mem_err", mem_err, 0);  chk("rst_br_taken", br_taken, 0);
    chk("rst_wb_data", wb_data, 0);  chk("rst_ex_ready", ex_ready, 1);
    @(posedge clk); #1 rst = 1'b0;

    // ALU op followed back-to-back by a second ALU op
    bundle(0, 32'h10, 0, 5'd8, 0, 0, 0, 0, 1);
    @(posedge clk); #1 bundle(0, 32'h20, 0, 5'd9, 0, 0, 0, 0, 1);
    @(negedge clk);
    chk("alu_wb_valid", wb_valid, 1); chk("alu_wb_data", wb_data, 32'h10);
    chk("alu_wb_rd", wb_r_d, 8);      chk("alu_wb_we", wb_reg_write, 1);
    chk("alu_ex_ready_b2b", ex_ready, 1);
    accept_one();
    @(negedge clk);
    chk("alu2_wb_valid", wb_valid, 1); chk("alu2_wb_data", wb_data, 32'h20);
    chk("alu2_wb_rd", wb_r_d, 9);
    @(negedge clk); chk("alu_idle_wb_valid", wb_valid, 0);

    // Load, ack on the 3rd request cycle
    bundle(0, 32'h100, 0, 5'd3, 0, 1, 0, 0, 1);
    accept_one();
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      chk("ld_dm_req", dm_req, 1);  chk("ld_dm_addr", dm_addr, 32'h100);
      chk("ld_dm_we", dm_we, 0);    chk("ld_ex_ready", ex_ready, 0);
      chk("ld_wb_valid", wb_valid, 0);
      if (c == 2) begin @(posedge clk); #1 dm_ack = 1; dm_rdata = 32'hCAFEBABE; end
      else if (c == 1) @(posedge clk);
    end
    @(posedge clk); #1 dm_ack = 0; dm_rdata = 0;
    @(negedge clk);
    chk("ld_req_drop", dm_req, 0);     chk("ld_wb_valid_hold", wb_valid, 1);
    chk("ld_wb_data", wb_data, 32'hCAFEBABE);
    chk("ld_wb_rd", wb_r_d, 3);        chk("ld_wb_we", wb_reg_write, 1);
    @(negedge clk); chk("ld_done_wb_valid", wb_valid, 0);

    // Store with 1-cycle ack, then 4 cycles of writeback backpressure
    wb_ready = 0;
    bundle(0, 32'h200, 32'h1234, 5'd4, 0, 0, 1, 0, 0);
    accept_one(); dm_ack = 1;
    @(negedge clk);
    chk("st_dm_req", dm_req, 1); chk("st_dm_we", dm_we, 1);
    chk("st_dm_wdata", dm_wdata, 32'h1234); chk("st_dm_addr", dm_addr, 32'h200);
    @(posedge clk); #1 dm_ack = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("st_wb_valid", wb_valid, 1);  chk("st_wb_data", wb_data, 32'h200);
      chk("st_wb_we", wb_reg_write, 0); chk("st_ex_ready", ex_ready, 0);
      chk("st_dm_req_low", dm_req, 0);
      if (c < 3) @(posedge clk);
    end
    @(posedge clk); #1 wb_ready = 1;
    @(negedge clk); chk("st_ex_ready_rel", ex_ready, 1); chk("st_wb_valid_rel", wb_valid, 1);
    @(negedge clk); chk("st_done_wb_valid", wb_valid, 0);

    // Branch taken, then not taken
    bundle(32'h40, 32'h0, 0, 5'd0, 1, 0, 0, 1, 0);
    accept_one();
    @(negedge clk);
    chk("br_taken", br_taken, 1); chk("br_target", br_target, 32'h40);
    chk("br_wb_valid", wb_valid, 1);
    @(negedge clk); chk("br_pulse_end", br_taken, 0);
    bundle(32'h80, 32'h4, 0, 5'd0, 0, 0, 0, 1, 0);
    accept_one();
    @(negedge clk); chk("br_nt_taken", br_taken, 0);
    @(negedge clk); chk("br_nt_taken2", br_taken, 0);

    // Write to r0 suppressed
    bundle(0, 32'h77, 0, 5'd0, 0, 0, 0, 0, 1);
    accept_one();
    @(negedge clk); chk("r0_wb_we", wb_reg_write, 0); chk("r0_wb_valid", wb_valid, 1);
    @(negedge clk);

    // Misaligned load
    bundle(0, 32'h102, 0, 5'd6, 0, 1, 0, 0, 1);
    accept_one();
    @(negedge clk);
    chk("mis_dm_req", dm_req, 0); chk("mis_mem_err", mem_err, 1);
    chk("mis_wb_valid", wb_valid, 1); chk("mis_wb_we", wb_reg_write, 0);
    chk("mis_wb_data", wb_data, 0);
    @(negedge clk); chk("mis_err_sticky", mem_err, 1);

    // Timeout: clear mem_err first, then a load that never gets acked
    do_reset();
    @(negedge clk); chk("to_err_cleared", mem_err, 0);
    bundle(0, 32'h300, 0, 5'd5, 0, 1, 0, 0, 1);
    accept_one();
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!dm_req) break;
      n++;
    end
    chk("to_req_cycles", n, 16);   chk("to_mem_err", mem_err, 1);
    chk("to_wb_valid", wb_valid, 1); chk("to_wb_data", wb_data, 0);
    chk("to_wb_we", wb_reg_write, 0);
    @(negedge clk);

    // Reset in the 2nd MEM_WAIT cycle, late ack ignored, then a normal bundle
    bundle(0, 32'h400, 0, 5'd2, 0, 1, 0, 0, 1);
    accept_one();
    @(negedge clk); chk("rm_req_c1", dm_req, 1);
    @(negedge clk); chk("rm_req_c2", dm_req, 1);
    #2 rst = 1'b1;
    #1;
    chk("rm_dm_req", dm_req, 0); chk("rm_wb_valid", wb_valid, 0);
    chk("rm_mem_err", mem_err, 0);
    @(posedge clk); #1 rst = 1'b0; dm_ack = 1; dm_rdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("rm_late_ack_req", dm_req, 0); chk("rm_late_ack_wbv", wb_valid, 0);
    chk("rm_ex_ready", ex_ready, 1);
    @(posedge clk); #1 dm_ack = 0;
    @(negedge clk); chk("rm_late_ack_wbv2", wb_valid, 0);
    bundle(0, 32'h55, 0, 5'd7, 0, 0, 0, 0, 1);
    accept_one();
    @(negedge clk);
    chk("rm_next_wbv", wb_valid, 1);  chk("rm_next_data", wb_data, 32'h55);
    chk("rm_next_rd", wb_r_d, 7);     chk("rm_next_we", wb_reg_write, 1);
    chk("rm_next_err", mem_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
